// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the data-RAM arbiter: FSM states, port ids,
// RAM size default and the word-address legality check.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int NUM_PORTS         = 2;
    localparam int MEM_BYTES_DEFAULT = 256;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_id_t;

    // A word access is legal when aligned and the whole word fits in the RAM.
    function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] mem_bytes);
        return (addr[1:0] == 2'b00) && (addr <= (mem_bytes - 64'd4));
    endfunction

endpackage

// File: rtl/dram_arb_pick.sv
// Combinational winner select for the two requesters. prio names the port
// that wins when both request; tie it to 0 for fixed priority.
module dram_arb_pick
    import dram_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  port_id_t prio,
    output logic     grant_valid,
    output port_id_t grant_id
);

    // Pick the winner among the active requests.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (req0 && req1) begin
            grant_valid = 1'b1;
            grant_id    = prio;
        end else if (req0) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (req1) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end else begin
            grant_valid = 1'b0;
            grant_id    = 1'b0;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter and access sequencer for the 256-byte data RAM.
// Define DRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t            state_r, state_next_s;
    logic              take_s;
    logic              grant_valid_s;
    port_id_t          grant_id_s;
    port_id_t          prio_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_legal_s;

    logic              we_r;
    port_id_t          port_r;
    logic              ack0_r, ack1_r, err0_r, err1_r, ram_rw_r;
    logic [DATA_W-1:0] rdata_r, ram_din_r;
    logic [ADDR_W-1:0] ram_addr_r;

    dram_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .prio        (prio_s),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

`ifdef DRAM_ARB_RR_EN
    port_id_t ptr_r;

    // Round-robin pointer: the port that did not win gets the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (take_s) begin
            ptr_r <= ~grant_id_s;
        end
    end

    assign prio_s = ptr_r;
`else
    assign prio_s = 1'b0;
`endif

    // Route the winning port's request fields.
    always_comb begin
        sel_we_s    = we0;
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
        if (grant_id_s == 1'b1) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    assign sel_legal_s = addr_legal(64'(sel_addr_s), 64'(MEM_BYTES));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; illegal requests skip ACCESS and answer straight away.
    always_comb begin
        state_next_s = state_r;
        take_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    take_s       = 1'b1;
                    state_next_s = sel_legal_s ? ACCESS : RESP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS:  state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Registered RAM drive, acknowledges and read data; ram_rw is high only while in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r       <= 1'b0;
            port_r     <= 1'b0;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            err0_r     <= 1'b0;
            err1_r     <= 1'b0;
            ram_rw_r   <= 1'b0;
            rdata_r    <= {DATA_W{1'b0}};
            ram_addr_r <= {ADDR_W{1'b0}};
            ram_din_r  <= {DATA_W{1'b0}};
        end else begin
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            err0_r   <= 1'b0;
            err1_r   <= 1'b0;
            ram_rw_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        we_r   <= sel_we_s;
                        port_r <= grant_id_s;
                        if (sel_legal_s) begin
                            ram_addr_r <= sel_addr_s;
                            ram_din_r  <= sel_wdata_s;
                            ram_rw_r   <= sel_we_s;
                        end else begin
                            ack0_r  <= (grant_id_s == 1'b0);
                            ack1_r  <= (grant_id_s == 1'b1);
                            err0_r  <= (grant_id_s == 1'b0);
                            err1_r  <= (grant_id_s == 1'b1);
                            rdata_r <= {DATA_W{1'b0}};
                        end
                    end
                end
                ACCESS: begin
                    if (!we_r) begin
                        rdata_r <= ram_dout;
                    end
                    ack0_r <= (port_r == 1'b0);
                    ack1_r <= (port_r == 1'b1);
                end
                default: begin
                end
            endcase
        end
    end

    assign ack0     = ack0_r;
    assign ack1     = ack1_r;
    assign err0     = err0_r;
    assign err1     = err1_r;
    assign rdata    = rdata_r;
    assign ram_addr = ram_addr_r;
    assign ram_din  = ram_din_r;
    assign ram_rw   = ram_rw_r;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural byte RAM.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_v, we_v;
    logic [31:0] addr_v [2];
    logic [31:0] wdata_v [2];
    logic        ack0, ack1, err0, err1, ram_rw;
    logic [31:0] rdata, ram_addr, ram_din, ram_dout;

    dram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req_v[0]), .req1(req_v[1]), .we0(we_v[0]), .we1(we_v[1]),
        .addr0(addr_v[0]), .addr1(addr_v[1]), .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_rw(ram_rw), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational big-endian read, write at negedge while RW is high.
    logic [7:0] mem [0:255];
    logic [7:0] mem_snap [0:255];
    logic [7:0] ra;
    assign ra       = ram_addr[7:0];
    assign ram_dout = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        forever begin
            @(negedge clk);
            if (ram_rw) begin
                mem[ra]        = ram_din[31:24];
                mem[ra + 8'd1] = ram_din[23:16];
                mem[ra + 8'd2] = ram_din[15:8];
                mem[ra + 8'd3] = ram_din[7:0];
            end
        end
    end

    // Reference model state
    int          chk_cnt = 0, err_cnt = 0;
    int          cyc = 0, free_at = 0;
    bit          rsp_v = 0, rsp_err = 0;
    int          rsp_cyc = 0, rsp_port = 0;
    logic [31:0] rsp_rdata = 0, exp_rdata = 0;
    int          rw_cyc = -1;
    logic [31:0] rw_addr = 0, rw_data = 0;
    bit          wr_pend = 0;
    int          wr_idx = 0;
    logic [31:0] wr_dat = 0;
    logic [31:0] shadow [0:63];
    bit [1:0]    hold = 2'b00, just_dropped = 2'b00;
`ifdef DRAM_ARB_RR_EN
    int          rr_next = 0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        rsp_v     = 0;
        rw_cyc    = -1;
        wr_pend   = 0;
        exp_rdata = 32'd0;
        free_at   = cyc + 1;
`ifdef DRAM_ARB_RR_EN
        rr_next   = 0;
`endif
    endtask

    // One arbitration decision per free slot, from the request values the edge just sampled.
    task automatic model_step();
        int          w;
        logic [31:0] a;
        bit          legal;
        if (cyc >= free_at && (req_v[0] || req_v[1])) begin
`ifdef DRAM_ARB_RR_EN
            if (req_v[0] && req_v[1]) w = rr_next;
            else w = req_v[0] ? 0 : 1;
            rr_next = 1 - w;
`else
            w = req_v[0] ? 0 : 1;
`endif
            a        = addr_v[w];
            legal    = (a % 4 == 0) && (a <= 252);
            rsp_v    = 1;
            rsp_port = w;
            if (!legal) begin
                rsp_cyc   = cyc;
                rsp_err   = 1;
                rsp_rdata = 32'd0;
                free_at   = cyc + 2;
            end else begin
                rsp_cyc = cyc + 1;
                rsp_err = 0;
                free_at = cyc + 3;
                if (we_v[w]) begin
                    rsp_rdata = exp_rdata;
                    rw_cyc    = cyc;
                    rw_addr   = a;
                    rw_data   = wdata_v[w];
                    wr_pend   = 1;
                    wr_idx    = a / 4;
                    wr_dat    = wdata_v[w];
                end else begin
                    rsp_rdata = shadow[a / 4];
                end
            end
        end
    endtask

    // Advance one clock, update the model, compare every output, let requesters react.
    task automatic tick();
        bit e0, e1, erw;
        @(posedge clk);
        #1;
        cyc++;
        if (wr_pend) begin
            shadow[wr_idx] = wr_dat;
            wr_pend = 0;
        end
        if (!rst_n) model_clear();
        else model_step();
        e0  = rsp_v && rsp_cyc == cyc && rsp_port == 0;
        e1  = rsp_v && rsp_cyc == cyc && rsp_port == 1;
        erw = (rw_cyc == cyc);
        chk("ack0", 32'(ack0), 32'(e0));
        chk("ack1", 32'(ack1), 32'(e1));
        chk("err0", 32'(err0), 32'(e0 && rsp_err));
        chk("err1", 32'(err1), 32'(e1 && rsp_err));
        chk("ram_rw", 32'(ram_rw), 32'(erw));
        if (e0 || e1) begin
            exp_rdata = rsp_rdata;
            chk("rdata", rdata, exp_rdata);
            rsp_v = 0;
        end
        if (erw) begin
            chk("ram_addr", ram_addr, rw_addr);
            chk("ram_din", ram_din, rw_data);
        end
        just_dropped = 2'b00;
        for (int p = 0; p < 2; p++) begin
            if ((p == 0 && e0) || (p == 1 && e1)) begin
                if (hold[p]) hold[p] = 1'b0;
                else begin
                    req_v[p] = 1'b0;
                    just_dropped[p] = 1'b1;
                end
            end
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ack"}, {30'd0, ack1, ack0}, 32'd0);
        chk({tag, "_err"}, {30'd0, err1, err0}, 32'd0);
        chk({tag, "_rw"}, 32'(ram_rw), 32'd0);
        chk({tag, "_raddr"}, ram_addr, 32'd0);
        chk({tag, "_rdin"}, ram_din, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
    endtask

    task automatic do_txn(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output int lat);
        req_v[p] = 1'b1; we_v[p] = w; addr_v[p] = a; wdata_v[p] = d;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if ((p == 0 && ack0) || (p == 1 && ack1)) lat = i;
        end
        req_v[p] = 1'b0;
        tick();
    endtask

    task automatic run_pair(output int t0, output int t1);
        req_v = 2'b11; we_v = 2'b00; addr_v[0] = 32'h10; addr_v[1] = 32'h4;
        t0 = 0; t1 = 0;
        for (int i = 1; i <= 12 && (t0 == 0 || t1 == 0); i++) begin
            tick();
            if (ack0 && t0 == 0) t0 = i;
            if (ack1 && t1 == 0) t1 = i;
        end
        req_v = 2'b00;
        tick();
    endtask

    initial begin
        int lat, t0, t1, a_first, a_second, diffs;
        for (int i = 0; i < 64; i++)
            shadow[i] = {8'(4*i*7+3), 8'((4*i+1)*7+3), 8'((4*i+2)*7+3), 8'((4*i+3)*7+3)};
        rst_n = 1'b0; req_v = 2'b00; we_v = 2'b00;
        addr_v[0] = 0; addr_v[1] = 0; wdata_v[0] = 0; wdata_v[1] = 0;
        repeat (3) tick();
        reset_checks("reset");
        rst_n = 1'b1;
        tick();

        // Write then read back through the other port
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, lat);
        chk("wr_latency", lat, 2);
        do_txn(1, 1'b0, 32'h10, 32'h0, lat);
        chk("rd_latency", lat, 2);
        chk("rd_data", rdata, 32'hDEADBEEF);
        chk("ram_byte10", 32'(mem[8'h10]), 32'hDE);
        chk("ram_byte13", 32'(mem[8'h13]), 32'hEF);

        // Illegal addresses: error ack one cycle after sampling, no RAM access
        mem_snap = mem;
        do_txn(0, 1'b0, 32'h12, 32'h0, lat);
        chk("misalign_latency", lat, 1);
        chk("misalign_rdata", rdata, 32'h0);
        do_txn(1, 1'b1, 32'h100, 32'hCAFEF00D, lat);
        chk("oor_latency", lat, 1);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== mem_snap[i]) diffs++;
        chk("ram_unchanged", diffs, 0);

        // Contention
        run_pair(t0, t1);
        chk("pair1_ack0", t0, 2);
        chk("pair1_ack1", t1, 5);
        do_txn(0, 1'b0, 32'h8, 32'h0, lat);
        run_pair(t0, t1);
`ifdef DRAM_ARB_RR_EN
        chk("pair2_ack1", t1, 2);
        chk("pair2_ack0", t0, 5);
`else
        chk("pair2_ack0", t0, 2);
        chk("pair2_ack1", t1, 5);
`endif

        // Reset in the middle of a write ACCESS
        do_txn(0, 1'b1, 32'h20, 32'h11223344, lat);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'h55667788;
        tick();
        chk("pre_reset_rw", 32'(ram_rw), 32'd1);
        #1;
        rst_n = 1'b0;
        model_clear();
        req_v = 2'b00; hold = 2'b00;
        #1;
        reset_checks("mid_reset");
        tick();
        tick();
        rst_n = 1'b1;
        do_txn(1, 1'b0, 32'h20, 32'h0, lat);
        chk("post_reset_latency", lat, 2);
        chk("post_reset_rdata", rdata, 32'h11223344);
        chk("post_reset_byte", 32'(mem[8'h20]), 32'h11);

        // Port 0 keeps req high past its ack
        hold[0] = 1'b1; req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h8;
        a_first = 0; a_second = 0;
        for (int i = 1; i <= 10 && a_second == 0; i++) begin
            tick();
            if (ack0) begin
                if (a_first == 0) a_first = i;
                else a_second = i;
            end
        end
        req_v = 2'b00; hold = 2'b00;
        tick();
        chk("hold_ack_first", a_first, 2);
        chk("hold_ack_second", a_second, 5);

        // Holding port 0 against a waiting port 1
        hold[0] = 1'b1; req_v = 2'b11; we_v = 2'b00; addr_v[0] = 32'h8; addr_v[1] = 32'hC;
        t1 = 0;
        for (int i = 1; i <= 14 && req_v != 2'b00; i++) begin
            tick();
            if (ack1 && t1 == 0) t1 = i;
        end
`ifdef DRAM_ARB_RR_EN
        chk("no_starve_ack1", t1, 2);
`else
        chk("fixed_ack1", t1, 8);
`endif
        req_v = 2'b00; hold = 2'b00;
        tick();

        // Randomized traffic from both ports
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_v[p] && !just_dropped[p] && $urandom_range(0, 2) == 0) begin
                    req_v[p] = 1'b1;
                    we_v[p]  = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 7))
                        0:       addr_v[p] = $urandom;
                        1:       addr_v[p] = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                        2:       addr_v[p] = 32'(256 + $urandom_range(0, 63) * 4);
                        default: addr_v[p] = 32'($urandom_range(0, 63) * 4);
                    endcase
                    wdata_v[p] = $urandom;
                    hold[p]    = ($urandom_range(0, 7) == 0);
                end
            end
            tick();
        end
        hold = 2'b00;
        for (int i = 0; i < 40 && (req_v != 2'b00 || rsp_v); i++) tick();
        chk("drain", {30'd0, req_v}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
